// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// -----------------------------------------------------------------------------
// Instruction-fetch front end for the 16-bit RISC core. Owns the program
// counter, issues one word fetch at a time to instruction memory and holds
// the returned instruction, together with its address and address+2, in a
// one-entry buffer for decode.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   imem_req       fetch request valid (accepted when imem_ready is also high)
//   imem_addr      fetch address, always even
//   imem_ready     memory accepts the request this cycle
//   imem_valid     read data valid, at least one cycle after accept
//   imem_rdata     instruction word returned by memory
//   redirect       one-cycle pulse: branch/jump taken
//   redirect_addr  redirect target (bit 0 ignored)
//   stall          decode cannot take the buffered instruction this cycle
//   inst_valid     inst/inst_pc/pc_plus2 hold a valid instruction
//   inst           fetched instruction
//   inst_pc        address of inst
//   pc_plus2       inst_pc + 2 (mod 2^16)
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    input  logic        stall,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic [15:0] pc_plus2
);

    typedef enum logic {
        FETCH,
        WAIT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic        drop;     // in-flight response belongs to a redirected-away path
    logic        accept;
    logic [15:0] pc_inc;

    // A request is only issued when the buffer is empty or being drained this
    // edge, so with one request outstanding the buffer can never overflow.
    always_comb begin
        imem_addr = pc;
        imem_req  = (state == FETCH) && !rst && !redirect && (!inst_valid || !stall);
        accept    = imem_req && imem_ready;
        pc_inc    = pc + 16'd2;
    end

    // Redirect needs no term here: it blocks the request in FETCH, and in
    // WAIT the response still returns us to FETCH whether kept or discarded.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: if (accept) state_next = WAIT;
            WAIT:  if (imem_valid) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC & 16'hFFFE;
            drop       <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            pc_plus2   <= '0;
        end else begin
            // Consume first; a load later in this block overrides the clear.
            if (inst_valid && !stall) begin
                inst_valid <= 1'b0;
            end

            if (redirect) begin
                pc         <= redirect_addr & 16'hFFFE;
                inst_valid <= 1'b0;
                // Response still outstanding: remember to throw it away.
                // Response arriving now: discarded here, nothing left to drop.
                if (state == WAIT) begin
                    drop <= !imem_valid;
                end
            end else if (state == WAIT && imem_valid) begin
                if (drop) begin
                    drop <= 1'b0;
                end else begin
                    inst       <= imem_rdata;
                    inst_pc    <= pc;
                    pc_plus2   <= pc_inc;
                    inst_valid <= 1'b1;
                    pc         <= pc_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// -----------------------------------------------------------------------------
// Bench for pc_fetch_unit. A behavioural memory with configurable latency and
// optional random back-pressure serves the main instance (RESET_PC=0x0100);
// a second instance (RESET_PC=0xFFFC) runs against a zero-wait memory to
// exercise address wrap. Directed scenarios check exact cycle behaviour; a
// randomized run checks the delivered instruction stream against a
// program-order reference (next expected address, redirect target).
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [15:0] pc_plus2;

    logic        w_req;
    logic [15:0] w_addr;
    logic        w_valid = 1'b0;
    logic [15:0] w_rdata = 16'h0000;
    logic        w_inst_valid;
    logic [15:0] w_inst;
    logic [15:0] w_inst_pc;
    logic [15:0] w_pc_plus2;

    int checks = 0;
    int errors = 0;

    int lat_min = 1;
    int lat_max = 1;
    bit rand_ready = 1'b0;

    logic        pend = 1'b0;
    logic [15:0] pend_addr = 16'h0000;
    int          pend_cnt = 0;

    pc_fetch_unit #(.RESET_PC(16'h0100)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_addr(redirect_addr), .stall(stall),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .pc_plus2(pc_plus2)
    );

    pc_fetch_unit #(.RESET_PC(16'hFFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1),
        .imem_valid(w_valid), .imem_rdata(w_rdata),
        .redirect(1'b0), .redirect_addr(16'h0000), .stall(1'b0),
        .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc), .pc_plus2(w_pc_plus2)
    );

    // Distinct word per address so stale data is always distinguishable.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // Main memory: latency in [lat_min, lat_max] cycles after accept.
    always @(posedge clk) begin : mem_model
        int l;
        imem_valid <= 1'b0;
        if (rst) begin
            pend       <= 1'b0;
            imem_ready <= 1'b1;
        end else begin
            imem_ready <= rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (pend) begin
                if (pend_cnt <= 1) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= mem_word(pend_addr);
                    pend       <= 1'b0;
                end else begin
                    pend_cnt <= pend_cnt - 1;
                end
            end
            if (imem_req && imem_ready) begin
                l = $urandom_range(lat_min, lat_max);
                if (l <= 1) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= mem_word(imem_addr);
                end else begin
                    pend      <= 1'b1;
                    pend_addr <= imem_addr;
                    pend_cnt  <= l - 1;
                end
            end
        end
    end

    // Zero-wait memory for the wrap instance.
    always @(posedge clk) begin
        w_valid <= !rst && w_req;
        w_rdata <= mem_word(w_addr);
    end

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_addr = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
        checks++; if ({inst, inst_pc, pc_plus2} !== 48'h0) begin errors++; $display("FAIL reset_buffer: got %h %h %h expected 0 0 0", inst, inst_pc, pc_plus2); end
        checks++; if (imem_addr !== 16'h0100) begin errors++; $display("FAIL reset_pc: got %h expected 0100", imem_addr); end
        checks++; if (w_addr !== 16'hFFFC || w_req !== 1'b0) begin errors++; $display("FAIL reset_wrap: got addr %h req %b expected FFFC 0", w_addr, w_req); end
    endtask

    task automatic test_sequential();
        logic        exp_v;
        logic [15:0] e;
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_v = (c >= 2) && (c % 2 == 0);
            e = 16'h0100 + 16'(c - 2);
            checks++; if (inst_valid !== exp_v) begin errors++; $display("FAIL seq_valid c=%0d: got %b expected %b", c, inst_valid, exp_v); end
            if (exp_v) begin
                checks++;
                if (inst_pc !== e || inst !== mem_word(e) || pc_plus2 !== e + 16'd2) begin
                    errors++; $display("FAIL seq_inst c=%0d: got pc %h inst %h p2 %h expected %h %h %h", c, inst_pc, inst, pc_plus2, e, mem_word(e), e + 16'd2);
                end
            end
            checks++; if (imem_req !== (c % 2 == 0)) begin errors++; $display("FAIL seq_req c=%0d: got %b expected %b", c, imem_req, (c % 2 == 0)); end
            if (c % 2 == 0) begin
                checks++; if (imem_addr !== 16'h0100 + 16'(c)) begin errors++; $display("FAIL seq_addr c=%0d: got %h expected %h", c, imem_addr, 16'h0100 + 16'(c)); end
            end
        end
    endtask

    task automatic test_stall();
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (2) @(negedge clk);
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req k=%0d: got %b expected 0", k, imem_req); end
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 16'h0100 || inst !== mem_word(16'h0100) || pc_plus2 !== 16'h0102) begin
                errors++; $display("FAIL stall_hold k=%0d: got v %b pc %h inst %h p2 %h expected 1 0100 %h 0102", k, inst_valid, inst_pc, inst, pc_plus2, mem_word(16'h0100));
            end
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0102) begin errors++; $display("FAIL stall_release: got req %b addr %h expected 1 0102", imem_req, imem_addr); end
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stall_release_valid: got %b expected 1", inst_valid); end
    endtask

    task automatic test_redirect_wait();
        lat_min = 3; lat_max = 3;
        do_reset();
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errors++; $display("FAIL rdw_first: got req %b addr %h expected 1 0100", imem_req, imem_addr); end
        @(negedge clk);
        redirect = 1'b1;
        redirect_addr = 16'h0A41;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_req_on_redirect: got %b expected 0", imem_req); end
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            redirect = 1'b0;
            #1;
            checks++; if (inst_valid !== (c == 8)) begin errors++; $display("FAIL rdw_valid c=%0d: got %b expected %b", c, inst_valid, (c == 8)); end
            if (c <= 3) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_wait_req c=%0d: got %b expected 0", c, imem_req); end
            end
            if (c == 4) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0A40) begin errors++; $display("FAIL rdw_target: got req %b addr %h expected 1 0A40", imem_req, imem_addr); end
            end
            if (c == 8) begin
                checks++;
                if (inst_pc !== 16'h0A40 || inst !== mem_word(16'h0A40) || pc_plus2 !== 16'h0A42) begin
                    errors++; $display("FAIL rdw_inst: got pc %h inst %h p2 %h expected 0A40 %h 0A42", inst_pc, inst, pc_plus2, mem_word(16'h0A40));
                end
            end
        end
    endtask

    task automatic test_redirect_coincident();
        lat_min = 2; lat_max = 2;
        do_reset();
        repeat (2) @(negedge clk);
        redirect = 1'b1;
        redirect_addr = 16'h1235;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdc_req_on_redirect: got %b expected 0", imem_req); end
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            redirect = 1'b0;
            #1;
            checks++; if (inst_valid !== (c == 6)) begin errors++; $display("FAIL rdc_valid c=%0d: got %b expected %b", c, inst_valid, (c == 6)); end
            if (c == 3) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h1234) begin errors++; $display("FAIL rdc_target: got req %b addr %h expected 1 1234", imem_req, imem_addr); end
            end
            if (c == 6) begin
                checks++;
                if (inst_pc !== 16'h1234 || inst !== mem_word(16'h1234)) begin
                    errors++; $display("FAIL rdc_inst: got pc %h inst %h expected 1234 %h", inst_pc, inst, mem_word(16'h1234));
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic        exp_v;
        logic [15:0] e;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_v = (c >= 2) && (c % 2 == 0);
            e = 16'hFFFC + 16'(c - 2);
            checks++; if (w_inst_valid !== exp_v) begin errors++; $display("FAIL wrap_valid c=%0d: got %b expected %b", c, w_inst_valid, exp_v); end
            if (exp_v) begin
                checks++;
                if (w_inst_pc !== e || w_inst !== mem_word(e) || w_pc_plus2 !== e + 16'd2) begin
                    errors++; $display("FAIL wrap_inst c=%0d: got pc %h inst %h p2 %h expected %h %h %h", c, w_inst_pc, w_inst, w_pc_plus2, e, mem_word(e), e + 16'd2);
                end
            end
            if (c % 2 == 0) begin
                checks++; if (w_req !== 1'b1 || w_addr !== 16'hFFFC + 16'(c)) begin errors++; $display("FAIL wrap_addr c=%0d: got req %b addr %h expected 1 %h", c, w_req, w_addr, 16'hFFFC + 16'(c)); end
            end
        end
    endtask

    task automatic test_rst_wait();
        lat_min = 3; lat_max = 3;
        do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rstw_req_in_rst: got %b expected 0", imem_req); end
        @(negedge clk);
        #1;
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rstw_after: got valid %b req %b expected 0 0", inst_valid, imem_req); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errors++; $display("FAIL rstw_restart: got req %b addr %h expected 1 0100", imem_req, imem_addr); end
    endtask

    // Reference: instructions must appear in program order starting at the
    // reset PC, restarting at each redirect target, each with its own memory
    // word; a held instruction must not change while stalled.
    task automatic test_random(input int ncycles);
        logic [15:0] exp_next;
        logic        held;
        logic [15:0] h_inst, h_pc, h_p2;
        int          idle;
        int          delivered;
        lat_min = 1; lat_max = 4;
        rand_ready = 1'b1;
        do_reset();
        exp_next = 16'h0100;
        held = 1'b0;
        h_inst = '0; h_pc = '0; h_p2 = '0;
        idle = 0;
        delivered = 0;
        for (int i = 0; i < ncycles; i++) begin
            if (i > 0) @(negedge clk);
            if (inst_valid) begin
                idle = 0;
                if (held) begin
                    checks++;
                    if ({inst, inst_pc, pc_plus2} !== {h_inst, h_pc, h_p2}) begin
                        errors++; $display("FAIL rand_hold cyc=%0d: got %h %h %h expected %h %h %h", i, inst, inst_pc, pc_plus2, h_inst, h_pc, h_p2);
                    end
                end else begin
                    delivered++;
                    checks++;
                    if (inst_pc !== exp_next || inst !== mem_word(exp_next) || pc_plus2 !== exp_next + 16'd2) begin
                        errors++; $display("FAIL rand_stream cyc=%0d: got pc %h inst %h p2 %h expected %h %h %h", i, inst_pc, inst, pc_plus2, exp_next, mem_word(exp_next), exp_next + 16'd2);
                    end
                    exp_next = inst_pc + 16'd2;
                end
            end else begin
                idle++;
                if (idle > 80) begin
                    checks++; errors++;
                    $display("FAIL rand_progress cyc=%0d: got %0d idle cycles expected at most 80", i, idle);
                    break;
                end
            end
            stall = ($urandom_range(0, 9) < 3);
            redirect = ($urandom_range(0, 24) == 0);
            redirect_addr = 16'($urandom);
            if (redirect) begin
                exp_next = redirect_addr & 16'hFFFE;
                idle = 0;
            end
            held = inst_valid && stall && !redirect;
            h_inst = inst; h_pc = inst_pc; h_p2 = pc_plus2;
            #1;
            checks++;
            if (imem_req && (redirect || (inst_valid && stall))) begin
                errors++; $display("FAIL rand_req_gate cyc=%0d: got req 1 expected 0 (redirect %b valid %b stall %b)", i, redirect, inst_valid, stall);
            end
            if (imem_req && imem_ready) begin
                checks++; if (imem_addr !== exp_next) begin errors++; $display("FAIL rand_fetch_addr cyc=%0d: got %h expected %h", i, imem_addr, exp_next); end
                checks++; if (pend || imem_valid) begin errors++; $display("FAIL rand_outstanding cyc=%0d: got 2 outstanding expected 1", i); end
            end
        end
        rand_ready = 1'b0;
        checks++; if (delivered < 100) begin errors++; $display("FAIL rand_delivered: got %0d expected at least 100", delivered); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_coincident();
        test_wrap();
        test_rst_wait();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
